ip_rom_arbiter: RTL and testbench



---
 rtl/ip_rom_arbiter_pkg.sv | 24 ++
 rtl/ip_rom_arbiter_client.sv | 68 ++++++
 rtl/ip_rom_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ip_rom_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ip_rom_arbiter_pkg
//  Description : Shared constants for the two-client ROM read arbiter:
//                FSM state encoding, client indices and the watchdog fill
//                byte returned when the memory never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ip_rom_arbiter_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    // Client indices; the owner register holds one of these
    localparam logic c_CLIENT_KANJI  = 1'b0;
    localparam logic c_CLIENT_MAPPER = 1'b1;

    // Byte handed back to the owner when the watchdog expires
    localparam logic [7:0] c_TIMEOUT_FILL = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/ip_rom_arbiter_client.sv
`default_nettype none
// ============================================================================
//  Module      : ip_rom_arbiter_client
//  Description : Per-client front end of the ROM arbiter. Captures a read
//                request and its address while idle, holds the pending flag
//                until the arbiter delivers data, and registers the client's
//                busy, rdata and rdata_en outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_rom_arbiter_client #(
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_deliver,
    input  logic [7:0]        i_data,
    output logic              o_busy,
    output logic              o_pend,
    output logic [ADDR_W-1:0] o_address,
    output logic [7:0]        o_rdata,
    output logic              o_rdata_en
);

    logic              r_busy;
    logic              r_pend;
    logic              r_rdata_en;
    logic [ADDR_W-1:0] r_address;
    logic [7:0]        r_rdata;
    logic              w_capture;

    // A request is only taken while the client is idle; later strobes are dropped
    assign w_capture = i_rd && !r_busy;

    // Busy spans capture through the data pulse and drops the cycle after it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_pend     <= 1'b0;
            r_rdata_en <= 1'b0;
            r_address  <= '0;
            r_rdata    <= 8'h00;
        end else begin
            if (w_capture) begin
                r_busy    <= 1'b1;
                r_pend    <= 1'b1;
                r_address <= i_address;
            end else if (r_rdata_en) begin
                r_busy <= 1'b0;
            end
            // Delivery only happens while pending, so it never races a capture
            if (i_deliver) begin
                r_pend  <= 1'b0;
                r_rdata <= i_data;
            end
            r_rdata_en <= i_deliver;
        end
    end

    assign o_busy     = r_busy;
    assign o_pend     = r_pend;
    assign o_address  = r_address;
    assign o_rdata    = r_rdata;
    assign o_rdata_en = r_rdata_en;

endmodule
`default_nettype wire

// File: rtl/ip_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ip_rom_arbiter
//  Description : Arbitrates two byte-read clients (0 = KanjiROM, 1 = ROM
//                mapper) onto a single external memory read port. One memory
//                transaction is outstanding at a time; round-robin between
//                clients when both are pending; data goes only to the owner.
//                Optional watchdog: define ROM_ARB_TIMEOUT_EN to return
//                8'hFF to the owner after TIMEOUT cycles without data.
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_rom_arbiter
    import ip_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 22,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_rd,
    output logic              c0_busy,
    input  logic [ADDR_W-1:0] c0_address,
    output logic [7:0]        c0_rdata,
    output logic              c0_rdata_en,
    input  logic              c1_rd,
    output logic              c1_busy,
    input  logic [ADDR_W-1:0] c1_address,
    output logic [7:0]        c1_rdata,
    output logic              c1_rdata_en,
    output logic              mem_rd,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rdata_en
);

    logic [1:0]        w_rd;
    logic [1:0]        w_busy;
    logic [1:0]        w_pend;
    logic [1:0]        w_deliver;
    logic [1:0]        w_rdata_en;
    logic [ADDR_W-1:0] w_req_addr [2];
    logic [ADDR_W-1:0] w_lat_addr [2];
    logic [7:0]        w_rdata    [2];
    logic [ADDR_W-1:0] w_owner_addr;
    logic              w_timeout;
    logic              w_done;
    logic [7:0]        w_done_data;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_rr_ptr;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_address;

    assign w_rd          = {c1_rd, c0_rd};
    assign w_req_addr[0] = c0_address;
    assign w_req_addr[1] = c1_address;

    for (genvar gi = 0; gi < 2; gi++) begin : g_client
        ip_rom_arbiter_client #(
            .ADDR_W (ADDR_W)
        ) u_client (
            .clk        (clk),
            .reset      (reset),
            .i_rd       (w_rd[gi]),
            .i_address  (w_req_addr[gi]),
            .i_deliver  (w_deliver[gi]),
            .i_data     (w_done_data),
            .o_busy     (w_busy[gi]),
            .o_pend     (w_pend[gi]),
            .o_address  (w_lat_addr[gi]),
            .o_rdata    (w_rdata[gi]),
            .o_rdata_en (w_rdata_en[gi])
        );
    end

`ifdef ROM_ARB_TIMEOUT_EN
    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;

    // Watchdog counts WAIT cycles; it fires on the TIMEOUT-th one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != c_ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_wait_cnt == c_CNT_LAST);
`else
    // Without the watchdog WAIT holds until the memory answers
    assign w_timeout = 1'b0;
`endif

    // Transaction completes in WAIT on memory data (or watchdog expiry);
    // data arriving in any other state is stale and ignored
    always_comb begin
        w_done      = 1'b0;
        w_done_data = mem_rdata;
        if (r_state == c_ST_WAIT) begin
            if (mem_rdata_en) begin
                w_done = 1'b1;
            end else if (w_timeout) begin
                w_done      = 1'b1;
                w_done_data = c_TIMEOUT_FILL;
            end
        end
    end

    assign w_deliver[0] = w_done && (r_owner == c_CLIENT_KANJI);
    assign w_deliver[1] = w_done && (r_owner == c_CLIENT_MAPPER);
    assign w_owner_addr = (r_owner == c_CLIENT_MAPPER) ? w_lat_addr[1] : w_lat_addr[0];

    // Arbiter FSM: pick an owner, strobe the memory once, wait for its data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_owner       <= c_CLIENT_KANJI;
            r_rr_ptr      <= c_CLIENT_KANJI;
            r_mem_rd      <= 1'b0;
            r_mem_address <= '0;
        end else begin
            r_mem_rd <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_pend) begin
                        if (&w_pend) begin
                            r_owner <= r_rr_ptr;
                        end else if (w_pend[1]) begin
                            r_owner <= c_CLIENT_MAPPER;
                        end else begin
                            r_owner <= c_CLIENT_KANJI;
                        end
                        r_state <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (!mem_busy) begin
                        r_mem_rd      <= 1'b1;
                        r_mem_address <= w_owner_addr;
                        r_state       <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (w_done) begin
                        // Favour the client that was not just served
                        r_rr_ptr <= ~r_owner;
                        r_state  <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign c0_busy     = w_busy[0];
    assign c0_rdata    = w_rdata[0];
    assign c0_rdata_en = w_rdata_en[0];
    assign c1_busy     = w_busy[1];
    assign c1_rdata    = w_rdata[1];
    assign c1_rdata_en = w_rdata_en[1];
    assign mem_rd      = r_mem_rd;
    assign mem_address = r_mem_address;

endmodule
`default_nettype wire

// File: tb/tb_ip_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ip_rom_arbiter
//  Description : Self-checking bench for ip_rom_arbiter: directed scenarios
//                followed by randomized traffic scored against a
//                transaction-level model of the two clients and the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_rom_arbiter;

    localparam int ADDR_W  = 22;
    localparam int TIMEOUT = 63;

    logic              clk = 1'b0;
    logic              reset;
    logic              c0_rd, c1_rd;
    logic [ADDR_W-1:0] c0_address, c1_address;
    logic              c0_busy, c1_busy;
    logic [7:0]        c0_rdata, c1_rdata;
    logic              c0_rdata_en, c1_rdata_en;
    logic              mem_rd, mem_busy, mem_rdata_en;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_rdata;

    logic [1:0] w_en_v, w_busy_v;
    logic [7:0] w_rdata_v [2];
    assign w_en_v       = {c1_rdata_en, c0_rdata_en};
    assign w_busy_v     = {c1_busy, c0_busy};
    assign w_rdata_v[0] = c0_rdata;
    assign w_rdata_v[1] = c1_rdata;

    always #5 clk = ~clk;

    ip_rom_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .c0_rd        (c0_rd),
        .c0_busy      (c0_busy),
        .c0_address   (c0_address),
        .c0_rdata     (c0_rdata),
        .c0_rdata_en  (c0_rdata_en),
        .c1_rd        (c1_rd),
        .c1_busy      (c1_busy),
        .c1_address   (c1_address),
        .c1_rdata     (c1_rdata),
        .c1_rdata_en  (c1_rdata_en),
        .mem_rd       (mem_rd),
        .mem_busy     (mem_busy),
        .mem_address  (mem_address),
        .mem_rdata    (mem_rdata),
        .mem_rdata_en (mem_rdata_en)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        c0_rd = 1'b0; c1_rd = 1'b0;
        c0_address = '0; c1_address = '0;
        mem_busy = 1'b0; mem_rdata_en = 1'b0; mem_rdata = 8'h00;
        step(); step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_mem_rd(input string tag);
        int k = 0;
        while (mem_rd !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk(tag, {31'd0, mem_rd}, 32'd1);
    endtask

    // Drive one memory data pulse and advance to the cycle the client sees it
    task automatic serve(input logic [7:0] d);
        mem_rdata    = d;
        mem_rdata_en = 1'b1;
        step();
        mem_rdata_en = 1'b0;
        mem_rdata    = 8'h00;
    endtask

    // Transaction-level model state for the random phase
    bit                mp_pend [2];
    logic [ADDR_W-1:0] mp_addr [2];
    bit                mp_pend_prev [2];
    bit                mp_outst, mp_sent, mp_prev_valid;
    int                mp_owner, mp_last, mp_prev_owner, mp_lat;
    logic [7:0]        mp_data;

    initial begin
        int                k;
        int                o;
        bit                seen;
        bit                rq [2];
        logic [ADDR_W-1:0] ra [2];

        // ---------------- reset state ----------------
        reset_dut();
        reset = 1'b1;
        step();
        chk("rst_c0_busy", c0_busy, 0);
        chk("rst_c1_busy", c1_busy, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_rdata_en", w_en_v, 0);
        chk("rst_rdata", {c1_rdata, c0_rdata}, 0);
        reset = 1'b0;
        step();

        // ---------------- single read, minimum latency ----------------
        c0_address = 22'h30_2B12; c0_rd = 1'b1;
        step();
        c0_rd = 1'b0; c0_address = '0;
        chk("t1_busy_n1", c0_busy, 1);
        chk("t1_memrd_n1", mem_rd, 0);
        step();
        chk("t1_memrd_n2", mem_rd, 0);
        step();
        chk("t1_memrd_n3", mem_rd, 1);
        chk("t1_mem_addr", mem_address, 22'h30_2B12);
        serve(8'h34);
        chk("t1_c0_en", c0_rdata_en, 1);
        chk("t1_c0_data", c0_rdata, 8'h34);
        chk("t1_c1_en", c1_rdata_en, 0);
        chk("t1_busy_at_en", c0_busy, 1);
        chk("t1_memrd_pulse", mem_rd, 0);
        step();
        chk("t1_c0_en_off", c0_rdata_en, 0);
        chk("t1_busy_off", c0_busy, 0);

        // ---------------- simultaneous requests ----------------
        reset_dut();
        c0_address = 22'h00_0100; c1_address = 22'h00_0200;
        c0_rd = 1'b1; c1_rd = 1'b1;
        step();
        c0_rd = 1'b0; c1_rd = 1'b0;
        wait_mem_rd("t2_first_rd");
        chk("t2_first_addr", mem_address, 22'h00_0100);
        serve(8'hAA);
        chk("t2_c0_en", c0_rdata_en, 1);
        chk("t2_c0_data", c0_rdata, 8'hAA);
        chk("t2_c1_en_quiet", c1_rdata_en, 0);
        wait_mem_rd("t2_second_rd");
        chk("t2_second_addr", mem_address, 22'h00_0200);
        serve(8'h55);
        chk("t2_c1_en", c1_rdata_en, 1);
        chk("t2_c1_data", c1_rdata, 8'h55);
        chk("t2_c0_en_quiet", c0_rdata_en, 0);
        chk("t2_c0_data_hold", c0_rdata, 8'hAA);
        step();

        // ---------------- memory stall ----------------
        mem_busy = 1'b1;
        c0_address = 22'h0A_BCDE; c0_rd = 1'b1;
        step();
        c0_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_stall_memrd", mem_rd, 0);
            chk("t3_stall_busy", c0_busy, 1);
        end
        mem_busy = 1'b0;
        wait_mem_rd("t3_rd");
        chk("t3_addr", mem_address, 22'h0A_BCDE);
        step();
        chk("t3_single_pulse", mem_rd, 0);
        serve(8'h3C);
        chk("t3_c0_en", c0_rdata_en, 1);
        chk("t3_c0_data", c0_rdata, 8'h3C);
        step();

        // ---------------- fairness under c0 hammering ----------------
        c0_address = 22'h11_1111; c0_rd = 1'b1;
        step();
        c0_address = 22'h22_2222;
        c1_address = 22'h33_3333; c1_rd = 1'b1;
        step();
        c1_rd = 1'b0;
        wait_mem_rd("t4_rd1");
        chk("t4_addr1", mem_address, 22'h11_1111);
        serve(8'h01);
        chk("t4_en1", c0_rdata_en, 1);
        wait_mem_rd("t4_rd2");
        chk("t4_addr2_c1", mem_address, 22'h33_3333);
        c0_rd = 1'b0;
        serve(8'h02);
        chk("t4_en2", c1_rdata_en, 1);
        chk("t4_data2", c1_rdata, 8'h02);
        wait_mem_rd("t4_rd3");
        chk("t4_addr3", mem_address, 22'h22_2222);
        serve(8'h03);
        chk("t4_en3", c0_rdata_en, 1);
        step();

        // ---------------- reset in WAIT, late data ----------------
        c1_address = 22'h3F_FFFF; c1_rd = 1'b1;
        step();
        c1_rd = 1'b0;
        wait_mem_rd("t5_rd");
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy_cleared", w_busy_v, 0);
        serve(8'h77);
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_en", w_en_v, 0);
            chk("t5_no_busy", w_busy_v, 0);
            chk("t5_no_memrd", mem_rd, 0);
            step();
        end
        chk("t5_rdata_cleared", c1_rdata, 0);
        c1_address = 22'h01_2345; c1_rd = 1'b1;
        step();
        c1_rd = 1'b0;
        wait_mem_rd("t5_next_rd");
        chk("t5_next_addr", mem_address, 22'h01_2345);
        serve(8'h9C);
        chk("t5_next_en", c1_rdata_en, 1);
        chk("t5_next_data", c1_rdata, 8'h9C);
        step();

        // ---------------- silent memory ----------------
        c1_address = 22'h2A_AAAA; c1_rd = 1'b1;
        step();
        c1_rd = 1'b0;
        wait_mem_rd("t6_rd");
`ifdef ROM_ARB_TIMEOUT_EN
        k = 0;
        while (c1_rdata_en !== 1'b1 && k < TIMEOUT + 20) begin
            step();
            k++;
        end
        chk("t6_timeout_en", c1_rdata_en, 1);
        chk("t6_timeout_latency", (k >= TIMEOUT && k <= TIMEOUT + 1), 1);
        chk("t6_timeout_data", c1_rdata, 8'hFF);
        chk("t6_c0_quiet", c0_rdata_en, 0);
        step();
        serve(8'h12);
        for (int i = 0; i < 3; i++) begin
            chk("t6_late_ignored", w_en_v, 0);
            step();
        end
        chk("t6_idle_busy", w_busy_v, 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (w_en_v != 2'b00) seen = 1'b1;
        end
        chk("t6_wait_holds", seen, 0);
        chk("t6_still_busy", c1_busy, 1);
        serve(8'h42);
        chk("t6_en", c1_rdata_en, 1);
        chk("t6_data", c1_rdata, 8'h42);
        step();
`endif

        // ---------------- randomized traffic ----------------
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            mp_pend[i] = 1'b0; mp_addr[i] = '0; mp_pend_prev[i] = 1'b0;
        end
        mp_outst = 1'b0; mp_sent = 1'b0; mp_prev_valid = 1'b0;
        mp_owner = 0; mp_last = 1; mp_prev_owner = 0; mp_lat = 0; mp_data = 8'h00;
        k = 0;
        while (k < 3400 && (k < 3000 || mp_outst || mp_pend[0] || mp_pend[1])) begin
            step();
            k++;
            // data returned to a client
            for (int i = 0; i < 2; i++) begin
                if (w_en_v[i]) begin
                    chk("rnd_en_owner", (mp_outst && mp_owner == i), 1);
                    chk("rnd_data", w_rdata_v[i], mp_data);
                    mp_pend[i] = 1'b0;
                    mp_outst   = 1'b0;
                    mp_last    = i;
                end
            end
            for (int i = 0; i < 2; i++) begin
                chk("rnd_busy", w_busy_v[i], (mp_pend[i] || w_en_v[i]));
            end
            // new memory transaction
            if (mem_rd) begin
                chk("rnd_one_outstanding", mp_outst, 0);
                o = -1;
                if (mp_pend[0] && mp_pend[1] && mp_addr[0] == mp_addr[1] && mp_addr[0] == mem_address)
                    o = 1 - mp_last;
                else if (mp_pend[0] && mp_addr[0] == mem_address)
                    o = 0;
                else if (mp_pend[1] && mp_addr[1] == mem_address)
                    o = 1;
                chk("rnd_mem_addr_valid", (o >= 0), 1);
                if (o >= 0) begin
                    chk("rnd_fairness", (mp_prev_valid && mp_prev_owner == o &&
                                         mp_pend[1-o] && mp_pend_prev[1-o]), 0);
                    mp_pend_prev[0] = mp_pend[0];
                    mp_pend_prev[1] = mp_pend[1];
                    mp_prev_owner   = o;
                    mp_prev_valid   = 1'b1;
                    mp_outst = 1'b1;
                    mp_owner = o;
                    mp_sent  = 1'b0;
                    mp_lat   = $urandom_range(0, 4);
                    mp_data  = 8'($urandom_range(0, 255));
                end
            end
            // memory responder, with stray data pulses while nothing is outstanding
            mem_rdata_en = 1'b0;
            mem_rdata    = 8'($urandom);
            if (mp_outst) begin
                if (!mp_sent) begin
                    if (mp_lat == 0) begin
                        mem_rdata_en = 1'b1;
                        mem_rdata    = mp_data;
                        mp_sent      = 1'b1;
                    end else begin
                        mp_lat--;
                    end
                end
            end else if ($urandom_range(0, 9) == 0) begin
                mem_rdata_en = 1'b1;
            end
            mem_busy = (k < 3000) && ($urandom_range(0, 3) == 0);
            // client requests; strobes while busy must be ignored
            for (int i = 0; i < 2; i++) begin
                rq[i] = (k < 3000) && ($urandom_range(0, 3) == 0);
                ra[i] = ADDR_W'($urandom);
                if (rq[i] && !(mp_pend[i] || w_en_v[i])) begin
                    mp_pend[i] = 1'b1;
                    mp_addr[i] = ra[i];
                end
            end
            c0_rd = rq[0]; c0_address = ra[0];
            c1_rd = rq[1]; c1_address = ra[1];
        end
        chk("rnd_drained", (!mp_outst && !mp_pend[0] && !mp_pend[1]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
